// File: rtl/tile_pkg.sv
// Shared tile-map geometry, player movement constants and tile attribute helpers.
package tile_pkg;

  localparam int unsigned TILE_SIZE   = 16;
  localparam int unsigned MAP_WIDTH   = 40;
  localparam int unsigned MAP_HEIGHT  = 30;
  localparam int unsigned STEP        = 2;
  localparam int unsigned START_X     = 320;
  localparam int unsigned START_Y     = 240;
  localparam int unsigned MAX_X       = 624;
  localparam int unsigned MAX_Y       = 464;
  localparam int unsigned ANIM_FRAMES = 8;
  localparam logic [7:0]  SPRITE_BASE = 8'd64;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;

  typedef enum logic [7:0] {
    GRASS  = 8'd0,
    PATH   = 8'd1,
    BRICK  = 8'd2,
    WATER  = 8'd3,
    TREE   = 8'd4,
    FLOWER = 8'd5
  } tile_id_e;

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'd0,
    DIR_UP    = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  function automatic logic is_solid(input logic [7:0] id);
    return (id == BRICK) || (id == WATER) || (id == TREE);
  endfunction

endpackage

// File: rtl/tilemap_tile_reader.sv
// Converts a pixel coordinate into a tilemap word fetch and returns the addressed tile byte.
module tilemap_tile_reader
  import tile_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [9:0]  px,
  input  logic [9:0]  py,
  input  logic [31:0] tm_data,
  output logic [10:0] tm_addr,
  output logic        tm_en,
  output logic [7:0]  tile_c,
  output logic        valid_c
);

  logic [10:0] index_c;
  logic [1:0]  byte_sel;
  logic [1:0]  stage;

  assign index_c = 11'(py >> 4) * 11'(MAP_WIDTH) + 11'(px >> 4);
  assign tile_c  = 8'(tm_data >> {byte_sel, 3'b000});
  assign valid_c = (stage == 2'd3);

  // stage 1 = address cycle, 2 = BRAM latency cycle, 3 = data present
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tm_addr  <= '0;
      tm_en    <= 1'b0;
      byte_sel <= '0;
      stage    <= '0;
    end else if (req) begin
      tm_addr  <= {2'b00, index_c[10:2]};
      byte_sel <= index_c[1:0];
      tm_en    <= 1'b1;
      stage    <= 2'd1;
    end else begin
      case (stage)
        2'd1:    stage <= 2'd2;
        2'd2: begin
          stage <= 2'd3;
          tm_en <= 1'b0;
        end
        default: stage <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/player_sprite_ctrl.sv
// Per-frame player movement: samples the key on vsync fall, checks two leading-edge tiles,
// then commits position and walk-cycle sprite tile.
module player_sprite_ctrl
  import tile_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic [7:0]  keycode,
  output logic [10:0] tm_addr,
  output logic        tm_en,
  input  logic [31:0] tm_data,
  output logic [9:0]  player_x,
  output logic [9:0]  player_y,
  output logic [7:0]  player_tile_id,
  output logic        player_enable,
  output logic        busy
);

  localparam int unsigned ANIM_W = $clog2(ANIM_FRAMES);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, SAMPLE, COMMIT} state_e;

  state_e              state;
  logic                vsync_q;
  dir_e                dir;
  dir_e                kdir;
  logic                frame;
  logic [ANIM_W-1:0]   anim_cnt;
  logic [9:0]          nx;
  logic [9:0]          ny;
  logic                corner;
  logic                blocked;

  logic                tick_c;
  logic                key_valid_c;
  dir_e                key_dir_c;
  logic [10:0]         x_w;
  logic [10:0]         y_w;
  logic [9:0]          cand_x_c;
  logic [9:0]          cand_y_c;
  logic [9:0]          base_x_c;
  logic [9:0]          base_y_c;
  dir_e                cdir_c;
  logic                second_c;
  logic                off_x_c;
  logic                off_y_c;
  logic [9:0]          px_c;
  logic [9:0]          py_c;
  logic                req_c;
  logic                wrap_c;
  logic                frame_next_c;
  logic [7:0]          rd_tile_c;
  logic                rd_valid_c;

  assign tick_c       = vsync_q & ~vsync;
  assign x_w          = {1'b0, player_x};
  assign y_w          = {1'b0, player_y};
  assign wrap_c       = (anim_cnt == ANIM_W'(ANIM_FRAMES - 1));
  assign frame_next_c = frame ^ wrap_c;
  assign req_c        = ((state == IDLE) && tick_c && key_valid_c) ||
                        ((state == SAMPLE) && !corner);

  // key decode and clamped candidate position
  always_comb begin
    key_valid_c = 1'b1;
    key_dir_c   = DIR_DOWN;
    cand_x_c    = player_x;
    cand_y_c    = player_y;
    case (keycode)
      KEY_W:   key_dir_c = DIR_UP;
      KEY_S:   key_dir_c = DIR_DOWN;
      KEY_A:   key_dir_c = DIR_LEFT;
      KEY_D:   key_dir_c = DIR_RIGHT;
      default: key_valid_c = 1'b0;
    endcase
    case (key_dir_c)
      DIR_LEFT:  cand_x_c = (x_w < 11'(STEP)) ? 10'd0 : 10'(x_w - 11'(STEP));
      DIR_RIGHT: cand_x_c = (x_w + 11'(STEP) > 11'(MAX_X)) ? 10'(MAX_X) : 10'(x_w + 11'(STEP));
      DIR_UP:    cand_y_c = (y_w < 11'(STEP)) ? 10'd0 : 10'(y_w - 11'(STEP));
      default:   cand_y_c = (y_w + 11'(STEP) > 11'(MAX_Y)) ? 10'(MAX_Y) : 10'(y_w + 11'(STEP));
    endcase
  end

  // Corner 0 is issued straight from the tick (candidate not yet registered), corner 1 from SAMPLE.
  always_comb begin
    second_c = (state != IDLE);
    base_x_c = second_c ? nx : cand_x_c;
    base_y_c = second_c ? ny : cand_y_c;
    cdir_c   = second_c ? kdir : key_dir_c;
    off_x_c  = 1'b0;
    off_y_c  = 1'b0;
    case (cdir_c)
      DIR_RIGHT: begin off_x_c = 1'b1;     off_y_c = second_c; end
      DIR_LEFT:  begin off_x_c = 1'b0;     off_y_c = second_c; end
      DIR_UP:    begin off_x_c = second_c; off_y_c = 1'b0;     end
      default:   begin off_x_c = second_c; off_y_c = 1'b1;     end
    endcase
    px_c = base_x_c + (off_x_c ? 10'(TILE_SIZE - 1) : 10'd0);
    py_c = base_y_c + (off_y_c ? 10'(TILE_SIZE - 1) : 10'd0);
  end

  tilemap_tile_reader u_reader (
    .clk     (clk),
    .reset   (reset),
    .req     (req_c),
    .px      (px_c),
    .py      (py_c),
    .tm_data (tm_data),
    .tm_addr (tm_addr),
    .tm_en   (tm_en),
    .tile_c  (rd_tile_c),
    .valid_c (rd_valid_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      vsync_q        <= 1'b1;
      player_x       <= 10'(START_X);
      player_y       <= 10'(START_Y);
      player_tile_id <= SPRITE_BASE;
      player_enable  <= 1'b0;
      busy           <= 1'b0;
      dir            <= DIR_DOWN;
      kdir           <= DIR_DOWN;
      frame          <= 1'b0;
      anim_cnt       <= '0;
      nx             <= '0;
      ny             <= '0;
      corner         <= 1'b0;
      blocked        <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (tick_c) player_enable <= 1'b1;
      case (state)
        IDLE: begin
          if (tick_c) begin
            if (key_valid_c) begin
              kdir    <= key_dir_c;
              nx      <= cand_x_c;
              ny      <= cand_y_c;
              corner  <= 1'b0;
              blocked <= 1'b0;
              busy    <= 1'b1;
              state   <= ADDR;
            end else begin
              // standing still: restart the walk cycle and show the rest frame
              frame          <= 1'b0;
              anim_cnt       <= '0;
              player_tile_id <= SPRITE_BASE + 8'({dir, 1'b0});
            end
          end
        end
        ADDR:   state <= WAIT;
        WAIT:   state <= SAMPLE;
        SAMPLE: begin
          blocked <= blocked | (rd_valid_c & is_solid(rd_tile_c));
          if (!corner) begin
            corner <= 1'b1;
            state  <= ADDR;
          end else begin
            state  <= COMMIT;
          end
        end
        COMMIT: begin
          dir <= kdir;
          if (!blocked) begin
            player_x <= nx;
            player_y <= ny;
          end
          anim_cnt       <= wrap_c ? '0 : anim_cnt + ANIM_W'(1);
          frame          <= frame_next_c;
          player_tile_id <= SPRITE_BASE + 8'({kdir, frame_next_c});
          busy           <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_player_sprite_ctrl.sv
// Directed bench for player_sprite_ctrl with a frame-level behavioural model and tilemap BRAM model.
module tb_player_sprite_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        vsync;
  logic [7:0]  keycode;
  logic [10:0] tm_addr;
  logic        tm_en;
  logic [31:0] tm_data = '0;
  logic [9:0]  player_x;
  logic [9:0]  player_y;
  logic [7:0]  player_tile_id;
  logic        player_enable;
  logic        busy;

  player_sprite_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .vsync          (vsync),
    .keycode        (keycode),
    .tm_addr        (tm_addr),
    .tm_en          (tm_en),
    .tm_data        (tm_data),
    .player_x       (player_x),
    .player_y       (player_y),
    .player_tile_id (player_tile_id),
    .player_enable  (player_enable),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int tiles [0:1199];

  // one-cycle registered read port
  always @(posedge clk) begin : bram
    int a;
    a = int'(tm_addr);
    if (tm_en && a < 300)
      tm_data <= {8'(tiles[4*a+3]), 8'(tiles[4*a+2]), 8'(tiles[4*a+1]), 8'(tiles[4*a])};
  end

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 0;

  int exp_x, exp_y, exp_tile;
  bit exp_enable, exp_busy;

  int m_x, m_y, m_dir, m_frame, m_cnt, p_tile;

  task automatic cmp(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      cmp("player_x", int'(player_x), exp_x);
      cmp("player_y", int'(player_y), exp_y);
      cmp("tile_id", int'(player_tile_id), exp_tile);
      cmp("enable", int'(player_enable), int'(exp_enable));
      cmp("busy", int'(busy), int'(exp_busy));
      if (!exp_busy) cmp("tm_en_idle", int'(tm_en), 0);
    end
  end

  function automatic bit solid_at(input int px, input int py);
    int id;
    id = tiles[(py / 16) * 40 + px / 16];
    return (id == 2) || (id == 3) || (id == 4);
  endfunction

  task automatic model_reset();
    m_x = 320; m_y = 240; m_dir = 0; m_frame = 0; m_cnt = 0;
    exp_x = 320; exp_y = 240; exp_tile = 64; exp_enable = 0; exp_busy = 0;
  endtask

  // one frame of player movement as the rules describe it
  task automatic model_tick(input logic [7:0] key, output bit mv);
    int d, nx, ny;
    bit blk;
    case (key)
      8'h1A:   d = 1;
      8'h16:   d = 0;
      8'h04:   d = 2;
      8'h07:   d = 3;
      default: d = -1;
    endcase
    if (d < 0) begin
      mv = 0; m_frame = 0; m_cnt = 0; p_tile = 64 + m_dir * 2;
      return;
    end
    nx = m_x; ny = m_y;
    case (d)
      2: nx = (m_x < 2) ? 0 : m_x - 2;
      3: nx = (m_x + 2 > 624) ? 624 : m_x + 2;
      1: ny = (m_y < 2) ? 0 : m_y - 2;
      default: ny = (m_y + 2 > 464) ? 464 : m_y + 2;
    endcase
    case (d)
      3: blk = solid_at(nx + 15, ny) | solid_at(nx + 15, ny + 15);
      2: blk = solid_at(nx, ny) | solid_at(nx, ny + 15);
      1: blk = solid_at(nx, ny) | solid_at(nx + 15, ny);
      default: blk = solid_at(nx, ny + 15) | solid_at(nx + 15, ny + 15);
    endcase
    m_dir = d;
    if (!blk) begin m_x = nx; m_y = ny; end
    m_cnt++;
    if (m_cnt == 8) begin m_cnt = 0; m_frame ^= 1; end
    p_tile = 64 + 2 * d + m_frame;
    mv = 1;
  endtask

  task automatic frame(input logic [7:0] key);
    bit mv;
    model_tick(key, mv);
    @(negedge clk);
    vsync = 1'b0; keycode = key; exp_enable = 1;
    if (mv) exp_busy = 1; else exp_tile = p_tile;
    @(negedge clk);
    vsync = 1'b1; keycode = 8'h16;
    repeat (6) @(negedge clk);
    if (mv) begin
      exp_x = m_x; exp_y = m_y; exp_tile = p_tile; exp_busy = 0;
    end
    repeat (3) @(negedge clk);
    keycode = 8'h00;
  endtask

  initial begin
    for (int i = 0; i < 1200; i++) tiles[i] = 0;
    reset = 1'b1; vsync = 1'b1; keycode = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    cmp("rst_tm_en", int'(tm_en), 0);
    reset = 1'b0;
    @(negedge clk);
    chk_on = 1;
    cmp("rst_x", int'(player_x), 320);
    cmp("rst_y", int'(player_y), 240);
    cmp("rst_tile", int'(player_tile_id), 64);
    cmp("rst_enable", int'(player_enable), 0);

    frame(8'h00);
    cmp("t1_enable", int'(player_enable), 1);
    cmp("t1_x", int'(player_x), 320);

    frame(8'h07);
    cmp("t2_x", int'(player_x), 322);
    cmp("t2_tile", int'(player_tile_id), 70);

    repeat (6) frame(8'h07);
    cmp("t5_tick7_tile", int'(player_tile_id), 70);
    frame(8'h07);
    cmp("t5_tick8_tile", int'(player_tile_id), 71);
    frame(8'h00);
    frame(8'h07);
    cmp("t5_restart_tile", int'(player_tile_id), 70);
    cmp("t5_x", int'(player_x), 338);

    repeat (18) frame(8'h04);
    cmp("t3_start_x", int'(player_x), 302);
    tiles[15*40+20] = 2;
    frame(8'h07);
    cmp("t3_x_move", int'(player_x), 304);
    frame(8'h07);
    cmp("t3_x_blocked", int'(player_x), 304);
    cmp("t3_dir_right", (int'(player_tile_id) - 64) / 2, 3);
    tiles[15*40+20] = 0;

    repeat (152) frame(8'h04);
    frame(8'h00);
    frame(8'h04);
    cmp("t4_x_min", int'(player_x), 0);
    cmp("t4_tile_left", int'(player_tile_id), 68);
    repeat (120) frame(8'h1A);
    frame(8'h00);
    frame(8'h1A);
    cmp("t4_y_min", int'(player_y), 0);
    cmp("t4_tile_up", int'(player_tile_id), 66);
    repeat (312) frame(8'h07);
    frame(8'h00);
    frame(8'h07);
    cmp("t4_x_max", int'(player_x), 624);

    // reset while corner 0 fetch is in its wait cycle
    @(negedge clk);
    vsync = 1'b0; keycode = 8'h07; exp_enable = 1; exp_busy = 1;
    @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    cmp("t6_x", int'(player_x), 320);
    cmp("t6_y", int'(player_y), 240);
    cmp("t6_tile", int'(player_tile_id), 64);
    cmp("t6_enable", int'(player_enable), 0);
    cmp("t6_busy", int'(busy), 0);
    cmp("t6_tm_en", int'(tm_en), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    frame(8'h07);
    cmp("t6_after_x", int'(player_x), 322);
    cmp("t6_after_tile", int'(player_tile_id), 70);

    tiles[16*40+21] = 3;
    frame(8'h16);
    cmp("water_blocks_y", int'(player_y), 240);
    tiles[16*40+21] = 5;
    frame(8'h16);
    cmp("flower_walkable_y", int'(player_y), 242);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
